// File: rtl/cam_pkg.sv
// cam_pkg: shared constants and types for the CAM return path.
//   CAM_ADDR_WIDTH / CAM_WIDTH / CAM_GROUP_SIZE : default geometry
//   CAM_DEPTH, CAM_GROUPS, CAM_GRP_IDX_W        : derived geometry
//   cam_index_t                                  : entry index type
//   cam_search_rsp_t                             : bundled search response
package cam_pkg;

  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_WIDTH      = 32;
  localparam int CAM_GROUP_SIZE = 8;

  localparam int CAM_DEPTH      = 1 << CAM_ADDR_WIDTH;
  localparam int CAM_GROUPS     = CAM_DEPTH / CAM_GROUP_SIZE;
  localparam int CAM_GRP_IDX_W  = (CAM_GROUPS > 1) ? $clog2(CAM_GROUPS) : 1;

  typedef logic [CAM_ADDR_WIDTH-1:0] cam_index_t;

  typedef struct packed {
    logic       valid;
    logic       hit;
    logic       multi;
    cam_index_t index;
  } cam_search_rsp_t;

endpackage

// File: rtl/cam_group_encoder.sv
// cam_group_encoder: combinational lowest-set-bit encoder.
//   vec   in  N      request vector
//   any   out 1      at least one bit set
//   multi out 1      two or more bits set
//   index out IDX_W  position of the lowest set bit (0 when none set)
module cam_group_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             any,
  output logic             multi,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    any   = 1'b0;
    multi = 1'b0;
    index = '0;
    // Scan from the top so the last assignment is the lowest set bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (any) multi = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_match_encoder.sv
// cam_match_encoder: collects CAM cell-array results for the response port.
//   clk_i, reset_i           clock, async active-high reset
//   search_enable_i, match_i search request and per-entry match lines
//   read_enable_i,
//   read_select_i,
//   read_data_i              one-hot read select and flattened entry data
//   clear_count_i            synchronous clear of the hit counter
//   search_valid_o/hit_o/
//   search_index_o/
//   multi_hit_o              search result, 2 cycles after the request
//   read_valid_o/
//   read_value_o             read result, 1 cycle after the request
//   hit_count_o              saturating count of hitting searches
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int GROUP_SIZE = CAM_GROUP_SIZE,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   search_enable_i,
  input  logic [DEPTH-1:0]       match_i,
  input  logic                   read_enable_i,
  input  logic [DEPTH-1:0]       read_select_i,
  input  logic [DEPTH*WIDTH-1:0] read_data_i,
  input  logic                   clear_count_i,
  output logic                   search_valid_o,
  output logic                   search_hit_o,
  output logic [ADDR_WIDTH-1:0]  search_index_o,
  output logic                   multi_hit_o,
  output logic                   read_valid_o,
  output logic [WIDTH-1:0]       read_value_o,
  output logic [CNT_WIDTH-1:0]   hit_count_o
);

  localparam int GROUPS   = DEPTH / GROUP_SIZE;
  localparam int OFF_BITS = $clog2(GROUP_SIZE);
  localparam int OFF_W    = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam int GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  // ---------------- search stage 1: per-group encode ----------------
  logic [GROUPS-1:0] s1_any_c;
  logic [GROUPS-1:0] s1_multi_c;
  logic [OFF_W-1:0]  s1_off_c [GROUPS];

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    cam_group_encoder #(
      .N     (GROUP_SIZE),
      .IDX_W (OFF_W)
    ) u_grp_enc (
      .vec   (match_i[g*GROUP_SIZE +: GROUP_SIZE]),
      .any   (s1_any_c[g]),
      .multi (s1_multi_c[g]),
      .index (s1_off_c[g])
    );
  end

  logic              s1_valid;
  logic [GROUPS-1:0] grp_any;
  logic [GROUPS-1:0] grp_multi;
  logic [OFF_W-1:0]  grp_off [GROUPS];

  // Group registers only load on an accepted search so idle cycles do not toggle them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid  <= 1'b0;
      grp_any   <= '0;
      grp_multi <= '0;
      for (int g = 0; g < GROUPS; g++) grp_off[g] <= '0;
    end else begin
      s1_valid <= search_enable_i;
      if (search_enable_i) begin
        grp_any   <= s1_any_c;
        grp_multi <= s1_multi_c;
        for (int g = 0; g < GROUPS; g++) grp_off[g] <= s1_off_c[g];
      end
    end
  end

  // ---------------- search stage 2: combine groups ----------------
  logic             hit_c;
  logic             grp_multi_hit_c;
  logic [GRP_W-1:0] win_grp_c;

  cam_group_encoder #(
    .N     (GROUPS),
    .IDX_W (GRP_W)
  ) u_combine_enc (
    .vec   (grp_any),
    .any   (hit_c),
    .multi (grp_multi_hit_c),
    .index (win_grp_c)
  );

  logic [OFF_W-1:0]      win_off_c;
  logic                  multi_c;
  logic [ADDR_WIDTH-1:0] index_c;

  always_comb begin
    win_off_c = grp_off[win_grp_c];
    multi_c   = (|grp_multi) | grp_multi_hit_c;
    index_c   = '0;
    // Gate with hit so a miss always reports index 0.
    if (hit_c) begin
      index_c = (ADDR_WIDTH'(win_grp_c) << OFF_BITS) | ADDR_WIDTH'(win_off_c);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      search_valid_o <= 1'b0;
      search_hit_o   <= 1'b0;
      search_index_o <= '0;
      multi_hit_o    <= 1'b0;
    end else begin
      search_valid_o <= s1_valid;
      if (s1_valid) begin
        search_hit_o   <= hit_c;
        search_index_o <= index_c;
        multi_hit_o    <= multi_c;
      end
    end
  end

  // Counter updates on the same edge the result is registered, so it moves with search_valid_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_count_o <= '0;
    end else if (clear_count_i) begin
      hit_count_o <= '0;
    end else if (s1_valid && hit_c && (hit_count_o != {CNT_WIDTH{1'b1}})) begin
      hit_count_o <= hit_count_o + 1'b1;
    end
  end

  // ---------------- read path ----------------
  logic [WIDTH-1:0] read_or_c;

  // Multi-hot select is legal and returns the OR of the selected entries.
  always_comb begin
    read_or_c = '0;
    for (int n = 0; n < DEPTH; n++) begin
      if (read_select_i[n]) read_or_c = read_or_c | read_data_i[n*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      read_valid_o <= 1'b0;
      read_value_o <= '0;
    end else begin
      read_valid_o <= read_enable_i;
      if (read_enable_i) read_value_o <= read_or_c;
    end
  end

endmodule

// File: tb/tb_cam_match_encoder.sv
module tb_cam_match_encoder;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_en;
  logic [D-1:0]  match;
  logic          r_en;
  logic [D-1:0]  r_sel;
  logic [D*W-1:0] r_data;
  logic          clr;
  logic          s_valid, s_hit, s_multi, r_valid;
  logic [AW-1:0] s_idx;
  logic [W-1:0]  r_value;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  cam_match_encoder #(
    .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .GROUP_SIZE(8), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .search_enable_i(s_en), .match_i(match),
    .read_enable_i(r_en), .read_select_i(r_sel), .read_data_i(r_data),
    .clear_count_i(clr),
    .search_valid_o(s_valid), .search_hit_o(s_hit), .search_index_o(s_idx),
    .multi_hit_o(s_multi), .read_valid_o(r_valid), .read_value_o(r_value),
    .hit_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one search, return at result time (+1 after the second edge).
  task automatic run_search(input logic [D-1:0] m);
    s_en = 1'b1; match = m;
    step();
    s_en = 1'b0; match = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_en = 0; match = '0; r_en = 0; r_sel = '0; r_data = '0; clr = 0;
    step(); step();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", s_valid); end
    total++; if ({s_hit, s_idx, s_multi} !== '0) begin bad++; $display("FAIL reset_search got=%0h exp=0", {s_hit, s_idx, s_multi}); end
    total++; if ({r_valid, r_value} !== '0) begin bad++; $display("FAIL reset_read got=%0h exp=0", {r_valid, r_value}); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    s_en = 1'b1; match = 32'h0000_0400;
    step();
    s_en = 1'b0; match = '0;
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0h exp=0", s_valid); end
    step();
    exp_cnt = 1;
    total++; if ({s_valid, s_hit, s_multi} !== 3'b110) begin bad++; $display("FAIL single_flags got=%b exp=110", {s_valid, s_hit, s_multi}); end
    total++; if (s_idx !== 5'd10) begin bad++; $display("FAIL single_idx got=%0d exp=10", s_idx); end
    total++; if (cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL single_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    step();
    total++; if ({s_valid, s_hit, s_idx} !== {1'b0, 1'b1, 5'd10}) begin bad++; $display("FAIL single_hold got=%0h exp=%0h", {s_valid, s_hit, s_idx}, {1'b0, 1'b1, 5'd10}); end
  endtask

  task automatic test_multi();
    run_search(32'h8000_0020);
    exp_cnt++;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b111, 5'd5}) begin bad++; $display("FAIL multi_cross got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b111, 5'd5}); end
    run_search(32'h0000_0006);
    exp_cnt++;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b111, 5'd1}) begin bad++; $display("FAIL multi_within got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b111, 5'd1}); end
    run_search(32'h0100_0000);
    exp_cnt++;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b110, 5'd24}) begin bad++; $display("FAIL multi_single_g3 got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b110, 5'd24}); end
    total++; if (cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL multi_cnt got=%0d exp=%0d", cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    s_en = 1'b1; match = 32'h0000_0001;
    step();
    match = 32'h0000_0000;
    step();
    exp_cnt++;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b110, 5'd0}) begin bad++; $display("FAIL b2b_r1 got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b110, 5'd0}); end
    match = 32'h8000_0000;
    step();
    s_en = 1'b0; match = '0;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b100, 5'd0}) begin bad++; $display("FAIL b2b_r2_miss got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b100, 5'd0}); end
    total++; if (cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL b2b_miss_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    step();
    exp_cnt++;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b110, 5'd31}) begin bad++; $display("FAIL b2b_r3 got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b110, 5'd31}); end
    step();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%0h exp=0", s_valid); end
  endtask

  task automatic test_read();
    r_data = '0;
    r_data[7*W +: W] = 32'hDEAD_BEEF;
    r_data[2*W +: W] = 32'h0000_0F00;
    r_data[3*W +: W] = 32'h1234_5678;
    r_en = 1'b1; r_sel = 32'h1 << 7;
    s_en = 1'b1; match = 32'h0001_0000;
    step();
    r_en = 1'b0; r_sel = '0; s_en = 1'b0; match = '0;
    total++; if ({r_valid, r_value} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL read_e7 got=%0h exp=%0h", {r_valid, r_value}, {1'b1, 32'hDEAD_BEEF}); end
    step();
    exp_cnt++;
    total++; if ({r_valid, r_value} !== {1'b0, 32'hDEAD_BEEF}) begin bad++; $display("FAIL read_hold got=%0h exp=%0h", {r_valid, r_value}, {1'b0, 32'hDEAD_BEEF}); end
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b110, 5'd16}) begin bad++; $display("FAIL read_concurrent_search got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b110, 5'd16}); end
    r_en = 1'b1; r_sel = '0;
    step();
    total++; if ({r_valid, r_value} !== {1'b1, 32'h0}) begin bad++; $display("FAIL read_zero_sel got=%0h exp=%0h", {r_valid, r_value}, {1'b1, 32'h0}); end
    r_sel = (32'h1 << 7) | (32'h1 << 2);
    step();
    r_en = 1'b0; r_sel = '0;
    total++; if (r_value !== 32'hDEAD_BFEF) begin bad++; $display("FAIL read_multi_hot got=%0h exp=deadbfef", r_value); end
    total++; if (cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL read_cnt got=%0d exp=%0d", cnt, exp_cnt); end
  endtask

  task automatic test_reset_midflight();
    s_en = 1'b1; match = 32'h0000_0004;
    step();
    s_en = 1'b0; match = '0;
    #2 rst = 1'b1;
    #1;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== '0) begin bad++; $display("FAIL midrst_search got=%0h exp=0", {s_valid, s_hit, s_multi, s_idx}); end
    total++; if ({r_valid, r_value} !== '0) begin bad++; $display("FAIL midrst_read got=%0h exp=0", {r_valid, r_value}); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", cnt); end
    exp_cnt = 0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost_valid cyc=%0d got=%0h exp=0", i, s_valid); end
    end
    run_search(32'h0000_2000);
    exp_cnt++;
    total++; if ({s_valid, s_hit, s_multi, s_idx} !== {3'b110, 5'd13}) begin bad++; $display("FAIL midrst_after got=%0h exp=%0h", {s_valid, s_hit, s_multi, s_idx}, {3'b110, 5'd13}); end
    total++; if (cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL midrst_after_cnt got=%0d exp=%0d", cnt, exp_cnt); end
  endtask

  task automatic test_counter();
    s_en = 1'b1; match = 32'h0000_0001;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 4) begin
        // results of issues 0..3 have landed on top of the current count
        total++; if (cnt !== CW'(exp_cnt + 4)) begin bad++; $display("FAIL cnt_mid got=%0d exp=%0d", cnt, exp_cnt + 4); end
      end
    end
    s_en = 1'b0; match = '0;
    step(); step();
    exp_cnt = 15;
    total++; if (cnt !== 4'd15) begin bad++; $display("FAIL cnt_saturate got=%0d exp=15", cnt); end
    s_en = 1'b1; match = 32'h0000_0100;
    step();
    s_en = 1'b0; match = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    total++; if ({s_valid, s_hit} !== 2'b11) begin bad++; $display("FAIL clr_hit_valid got=%b exp=11", {s_valid, s_hit}); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL clr_priority got=%0d exp=0", cnt); end
    run_search(32'h0000_0100);
    exp_cnt++;
    total++; if (cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL cnt_after_clr got=%0d exp=%0d", cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_read();
    test_reset_midflight();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_match_encoder.md
Name: cam_match_encoder

Overview:
- Return-path counterpart of the CAM address decoder.
- The decoder fans a write, read or search request out into per-entry enables. This block collects the per-entry results coming back from the CAM cell array:
  - match lines become a registered hit flag, lowest matching index and multi-hit flag;
  - selected-entry read data becomes a registered read word.
- Sits between the cell array and the CAM's external response interface.
- Search path is a 2-stage pipeline; read path is 1 stage.

Parameters:
- WIDTH, 32, bits per CAM entry.
- ADDR_WIDTH, 5, index width.
- DEPTH, 1<<ADDR_WIDTH, number of entries.
- GROUP_SIZE, 8, entries per stage-1 encoder group; must be a power of 2 and divide DEPTH.
- CNT_WIDTH, 16, width of the saturating hit counter.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset; asynchronous, active-high. Single clock domain.
- search_enable_i  input  1  match_i is valid this cycle.
- match_i  input  DEPTH  per-entry match lines; bit n = entry n matched.
- read_enable_i  input  1  read_select_i/read_data_i valid this cycle.
- read_select_i  input  DEPTH  one-hot per-entry read enables (the decoder's read enable vector).
- read_data_i  input  DEPTH*WIDTH  flattened entry data; entry n occupies bits [n*WIDTH +: WIDTH].
- clear_count_i  input  1  synchronous clear of hit_count_o.
- search_valid_o  output  1  search result valid.
- search_hit_o  output  1  at least one entry matched.
- search_index_o  output  ADDR_WIDTH  lowest matching index.
- multi_hit_o  output  1  two or more entries matched.
- read_valid_o  output  1  read result valid.
- read_value_o  output  WIDTH  read word.
- hit_count_o  output  CNT_WIDTH  number of searches that hit, saturating.

Behaviour:
- Reset: all outputs and all pipeline registers go to 0 immediately on reset_i high. In-flight searches and reads are discarded with no valid pulse. The first accepted input is the one sampled on the first rising edge after reset_i deasserts.
- Search stage 1 (edge N, search_enable_i=1):
  - For each of G = DEPTH/GROUP_SIZE groups, register: any, multi (2+ set within group), and lowest set local offset.
  - Register stage-1 valid = search_enable_i.
- Search stage 2 (edge N+1):
  - hit = OR of all group any flags.
  - winning group = lowest group with any=1.
  - index = {group number, local offset}.
  - multi = any group multi, OR 2+ groups with any.
  - Registered to outputs; search_valid_o asserts for exactly one cycle, 2 cycles after the input.
- Back-to-back searches every cycle are supported, throughput 1/cycle. No stall and no ready signal.
- search_enable_i=0: match_i is ignored. Stage-1 valid = 0, and group registers hold their previous values (no toggling).
- Miss (match_i = 0 with enable): valid=1, hit=0, index=0, multi=0.
- search_hit_o, search_index_o and multi_hit_o hold their last values while search_valid_o=0.
- Read path:
  - read_value_o = bitwise OR over n of (read_select_i[n] ? entry n : 0), registered.
  - read_valid_o = read_enable_i delayed 1 cycle.
  - All-zero select gives value 0.
  - Multi-hot select gives the OR of the selected entries; this is defined behaviour, not an error.
  - read_value_o holds its value when read_enable_i=0.
- Read and search are independent; simultaneous read and search are both serviced.
- hit_count_o:
  - Increments on each cycle where stage-2 produces valid=1 and hit=1.
  - Saturates at 2^CNT_WIDTH-1.
  - clear_count_i has priority: a clear coincident with a hit gives 0.
- Index width rule: group number occupies the upper ADDR_WIDTH-log2(GROUP_SIZE) bits; the local offset occupies the low log2(GROUP_SIZE) bits.

Decomposition:
- Package cam_pkg holds:
  - CAM_ADDR_WIDTH, CAM_WIDTH, CAM_GROUP_SIZE;
  - derived CAM_DEPTH, CAM_GROUPS, CAM_GRP_IDX_W;
  - typedef cam_index_t (logic [ADDR_WIDTH-1:0]);
  - struct cam_search_rsp_t {valid, hit, multi, index}.
- Sub-module cam_group_encoder: combinational GROUP_SIZE-bit lowest-index encoder with any/multi outputs, instantiated G times in stage 1.
- The stage-2 combine reuses cam_group_encoder on the G-bit vector of any flags.

Test Plan:
1. Single match: search_enable_i=1, match_i=32'h0000_0400 -> 2 cycles later valid=1, hit=1, index=10, multi=0; hit_count_o 0->1.
2. Multi-hit across groups: match_i=32'h8000_0020 -> index=5, multi=1. Within one group, match_i=32'h0000_0006 -> index=1, multi=1.
3. Back-to-back: match_i = 0x1, 0x0, 0x8000_0000 on 3 consecutive cycles -> valid for 3 consecutive cycles with (hit=1, idx=0), (hit=0, idx=0), (hit=1, idx=31).
4. Read: read_select_i=1<<7, entry 7 = 32'hDEAD_BEEF, concurrent with a search -> next cycle read_valid_o=1, read_value_o=32'hDEAD_BEEF; the search result is unaffected. All-zero select -> 0.
5. Reset mid-flight: issue a search, assert reset_i asynchronously between edges -> all outputs 0 immediately and no valid pulse afterwards; a search after deassert completes normally.
6. Counter: CNT_WIDTH=4, run 17 hitting searches -> hit_count_o stays at 15. clear_count_i together with a hit -> 0.
